// File: rtl/dphy_lane_aligner.sv
// D-PHY two-lane byte aligner.
//
// Hunts for the SoT leader byte (SYNC_BYTE) at any of the eight bit offsets on each lane once
// hs_active rises. When both lanes lock, it presents byte-aligned payload until hs_active falls.
// Failure to lock within SYNC_TIMEOUT hunt cycles, or a lock on one lane only, raises a one-cycle
// sync_err. After that the block parks until hs_active falls.
//
// Optional feature macro: DPHY_SKEW_COMP_EN. When it is defined, a lane may lock one byte before
// the other. That earlier lane is then delayed one byte so that both lanes stay byte-aligned.
//
// Ports:
//   byte_clk      - D-PHY byte clock; all state changes on its rising edge
//   rst_n         - asynchronous active-low reset
//   hs_active     - both lanes in HS mode
//   lane0_raw     - unaligned deserializer byte, lane 0 (bit0 received first)
//   lane1_raw     - unaligned deserializer byte, lane 1 (bit0 received first)
//   lane0_data    - aligned payload byte, lane 0 (0 when hs_burst_flag is low)
//   lane1_data    - aligned payload byte, lane 1 (0 when hs_burst_flag is low)
//   hs_burst_flag - lane data carries valid payload
//   sync_err      - one-cycle pulse on sync timeout or lane-sync mismatch
//   align_off0    - bit offset locked on lane 0
//   align_off1    - bit offset locked on lane 1
module dphy_lane_aligner #(
  parameter int unsigned SYNC_TIMEOUT = 8,  // must be >= 1
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic       byte_clk,
  input  logic       rst_n,
  input  logic       hs_active,
  input  logic [7:0] lane0_raw,
  input  logic [7:0] lane1_raw,
  output logic [7:0] lane0_data,
  output logic [7:0] lane1_data,
  output logic       hs_burst_flag,
  output logic       sync_err,
  output logic [2:0] align_off0,
  output logic [2:0] align_off1
);

  localparam int unsigned     CntW    = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(SYNC_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(SYNC_TIMEOUT - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHunt   = 2'd1;
  localparam logic [1:0] StBurst  = 2'd2;
  localparam logic [1:0] StWaitLp = 2'd3;

  function automatic logic [7:0] pick(input logic [15:0] win, input logic [2:0] k);
    return win[k +: 8];
  endfunction

  // Returns {hit, k}. The scan runs downward, so the lowest matching k is the one kept.
  function automatic logic [3:0] find_sync(input logic [15:0] win);
    logic [3:0] r;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      prev0_q, prev1_q;
  logic [2:0]      off0_q, off0_d, off1_q, off1_d;
  logic            flag_q, flag_d;
  logic [7:0]      data0_q, data0_d, data1_q, data1_d;
  logic [15:0]     win0, win1;
  logic [3:0]      fs0, fs1;
  logic            hit0, hit1, timeout, go_burst, fail;
  logic [2:0]      new_off0, new_off1;
  logic [7:0]      byte0, byte1;

  assign win0    = {lane0_raw, prev0_q};
  assign win1    = {lane1_raw, prev1_q};
  assign fs0     = find_sync(win0);
  assign fs1     = find_sync(win1);
  assign hit0    = fs0[3];
  assign hit1    = fs1[3];
  assign timeout = (cnt_q >= CntLast);

`ifdef DPHY_SKEW_COMP_EN
  // pend_*: one lane has locked and is waiting one cycle for the other lane.
  // dly_*: during the burst, the early lane is taken from skew_byte_q.
  logic       pend_q, pend_d, pend_lane_q, pend_lane_d;
  logic [2:0] pend_off_q, pend_off_d;
  logic       dly_en_q, dly_en_d, dly_lane_q, dly_lane_d;
  logic [7:0] skew_byte_q;
  logic       skew_lane, late_hit;
  logic [2:0] skew_off;

  assign late_hit  = pend_lane_q ? hit0 : hit1;
  assign skew_lane = (state_q == StBurst) ? dly_lane_q : pend_lane_q;
  assign skew_off  = (state_q == StBurst) ? (dly_lane_q ? off1_q : off0_q) : pend_off_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off0_d   = off0_q;
    off1_d   = off1_q;
    go_burst = 1'b0;
    fail     = 1'b0;
    new_off0 = fs0[2:0];
    new_off1 = fs1[2:0];
`ifdef DPHY_SKEW_COMP_EN
    pend_d      = pend_q;
    pend_lane_d = pend_lane_q;
    pend_off_d  = pend_off_q;
    dly_en_d    = dly_en_q;
    dly_lane_d  = dly_lane_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef DPHY_SKEW_COMP_EN
        pend_d = 1'b0;
`endif
        if (hs_active) state_d = StHunt;
      end
      StHunt: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
`ifdef DPHY_SKEW_COMP_EN
        if (pend_q) begin
          if (late_hit) begin
            go_burst   = 1'b1;
            dly_en_d   = 1'b1;
            dly_lane_d = pend_lane_q;
            new_off0   = pend_lane_q ? fs0[2:0] : pend_off_q;
            new_off1   = pend_lane_q ? pend_off_q : fs1[2:0];
          end else begin
            fail = 1'b1;
          end
        end else if (hit0 && hit1) begin
          go_burst = 1'b1;
          dly_en_d = 1'b0;
        end else if ((hit0 != hit1) && !timeout) begin
          pend_d      = 1'b1;
          pend_lane_d = hit1;
          pend_off_d  = hit1 ? fs1[2:0] : fs0[2:0];
        end else if ((hit0 != hit1) || timeout) begin
          fail = 1'b1;
        end
`else
        // The both-lane match is checked first, so it wins over a timeout in the same cycle.
        if (hit0 && hit1) begin
          go_burst = 1'b1;
        end else if ((hit0 != hit1) || timeout) begin
          fail = 1'b1;
        end
`endif
      end
      StBurst:  ;
      StWaitLp: ;
      default:  state_d = StIdle;
    endcase

    if (!hs_active) begin
      state_d = StIdle;
    end else if (go_burst) begin
      state_d = StBurst;
      off0_d  = new_off0;
      off1_d  = new_off1;
    end else if (fail) begin
      state_d = StWaitLp;
    end
  end

  always_comb begin
    byte0 = pick(win0, off0_q);
    byte1 = pick(win1, off1_q);
`ifdef DPHY_SKEW_COMP_EN
    if (dly_en_q && !dly_lane_q) byte0 = skew_byte_q;
    if (dly_en_q && dly_lane_q)  byte1 = skew_byte_q;
`endif
    flag_d  = (state_q == StBurst) && hs_active;
    data0_d = flag_d ? byte0 : 8'h00;
    data1_d = flag_d ? byte1 : 8'h00;
  end

  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prev0_q <= 8'h00;
      prev1_q <= 8'h00;
      off0_q  <= 3'd0;
      off1_q  <= 3'd0;
      flag_q  <= 1'b0;
      data0_q <= 8'h00;
      data1_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev0_q <= lane0_raw;
      prev1_q <= lane1_raw;
      off0_q  <= off0_d;
      off1_q  <= off1_d;
      flag_q  <= flag_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

`ifdef DPHY_SKEW_COMP_EN
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_lane_q <= 1'b0;
      pend_off_q  <= 3'd0;
      dly_en_q    <= 1'b0;
      dly_lane_q  <= 1'b0;
      skew_byte_q <= 8'h00;
    end else begin
      pend_q      <= pend_d;
      pend_lane_q <= pend_lane_d;
      pend_off_q  <= pend_off_d;
      dly_en_q    <= dly_en_d;
      dly_lane_q  <= dly_lane_d;
      skew_byte_q <= pick(skew_lane ? win1 : win0, skew_off);
    end
  end
`endif

  // The error is a decode of the current hunt cycle, so it lasts exactly one cycle.
  assign sync_err      = fail && hs_active && (state_q == StHunt);
  assign lane0_data    = data0_q;
  assign lane1_data    = data1_q;
  assign hs_burst_flag = flag_q;
  assign align_off0    = off0_q;
  assign align_off1    = off1_q;

endmodule

// File: tb/tb_dphy_lane_aligner.sv
// Directed bench for dphy_lane_aligner. Each lane is described as a bit stream, and the stream is
// cut into raw bytes, so a sync at bit offset k sits at stream bit 8*(m-1)+k. With that placement
// it is recognised in hunt cycle m, counting cycle 0 as the cycle in which hs_active rises.
module tb_dphy_lane_aligner;

  localparam logic [7:0] Sync = 8'hB8;

  logic       byte_clk, rst_n, hs_active;
  logic [7:0] lane0_raw, lane1_raw, lane0_data, lane1_data;
  logic       hs_burst_flag, sync_err;
  logic [2:0] align_off0, align_off1;

  dphy_lane_aligner #(.SYNC_TIMEOUT(8), .SYNC_BYTE(8'hB8)) dut (
    .byte_clk      (byte_clk),
    .rst_n         (rst_n),
    .hs_active     (hs_active),
    .lane0_raw     (lane0_raw),
    .lane1_raw     (lane1_raw),
    .lane0_data    (lane0_data),
    .lane1_data    (lane1_data),
    .hs_burst_flag (hs_burst_flag),
    .sync_err      (sync_err),
    .align_off0    (align_off0),
    .align_off1    (align_off1)
  );

  initial byte_clk = 1'b0;
  always #5 byte_clk = ~byte_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       obs_flag[16], obs_err[16];
  logic [7:0] obs_d0[16], obs_d1[16];
  logic [2:0] obs_o0[16], obs_o1[16];

  typedef struct {
    logic [2:0] k0, k1;              // sync bit offset placed on each lane
    logic [7:0] p0, p1;              // first payload byte on each lane
    logic [2:0] exp_off0, exp_off1;
    logic [7:0] exp_d0, exp_d1;      // first aligned byte expected
    logic [7:0] exp_d0b, exp_d1b;    // second aligned byte expected
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " data0"}, 32'(lane0_data), 32'h0);
    chk({nm, " data1"}, 32'(lane1_data), 32'h0);
    chk({nm, " flag"},  32'(hs_burst_flag), 32'h0);
    chk({nm, " err"},   32'(sync_err), 32'h0);
    chk({nm, " off0"},  32'(align_off0), 32'h0);
    chk({nm, " off1"},  32'(align_off1), 32'h0);
  endtask

  function automatic logic [127:0] mk(input int pos, input logic [7:0] p, input logic [7:0] p2);
    logic [127:0] s;
    s = '0;
    s[pos +: 8]      = Sync;
    s[pos + 8 +: 8]  = p;
    s[pos + 16 +: 8] = p2;
    return s;
  endfunction

  // Two idle cycles, then n_total cycles with hs_active high for the first n_hs of them.
  // Outputs are sampled on the falling edge of each cycle. If rst_at >= 0, reset is asserted
  // between clock edges in that cycle, and the block is taken back out of reset afterwards.
  task automatic play(input logic [127:0] s0, input logic [127:0] s1, input int n_hs,
                      input int n_total, input int rst_at);
    hs_active = 1'b0;
    lane0_raw = 8'h00;
    lane1_raw = 8'h00;
    repeat (2) @(posedge byte_clk);
    for (int c = 0; c < n_total; c++) begin
      @(posedge byte_clk);
      #1;
      hs_active = (c < n_hs);
      lane0_raw = (c < 16) ? s0[8*c +: 8] : 8'h00;
      lane1_raw = (c < 16) ? s1[8*c +: 8] : 8'h00;
      @(negedge byte_clk);
      obs_flag[c] = hs_burst_flag;
      obs_err[c]  = sync_err;
      obs_d0[c]   = lane0_data;
      obs_d1[c]   = lane1_data;
      obs_o0[c]   = align_off0;
      obs_o1[c]   = align_off1;
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async reset mid-burst");
        @(posedge byte_clk);
        #1;
        rst_n     = 1'b1;
        hs_active = 1'b0;
        break;
      end
    end
    hs_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{k0: 3'd0, k1: 3'd0, p0: 8'h11, p1: 8'h22, exp_off0: 3'd0, exp_off1: 3'd0,
                exp_d0: 8'h11, exp_d1: 8'h22, exp_d0b: 8'h33, exp_d1b: 8'h44};
    vecs[1] = '{k0: 3'd3, k1: 3'd5, p0: 8'hA5, p1: 8'h5A, exp_off0: 3'd3, exp_off1: 3'd5,
                exp_d0: 8'hA5, exp_d1: 8'h5A, exp_d0b: 8'h33, exp_d1b: 8'h44};
    vecs[2] = '{k0: 3'd7, k1: 3'd1, p0: 8'h3C, p1: 8'hC3, exp_off0: 3'd7, exp_off1: 3'd1,
                exp_d0: 8'h3C, exp_d1: 8'hC3, exp_d0b: 8'h33, exp_d1b: 8'h44};
    vecs[3] = '{k0: 3'd2, k1: 3'd6, p0: 8'hFF, p1: 8'h01, exp_off0: 3'd2, exp_off1: 3'd6,
                exp_d0: 8'hFF, exp_d1: 8'h01, exp_d0b: 8'h33, exp_d1b: 8'h44};

    rst_n     = 1'b0;
    hs_active = 1'b0;
    lane0_raw = 8'h00;
    lane1_raw = 8'h00;
    #3 chk_all_zero("reset state");
    @(posedge byte_clk);
    #1 rst_n = 1'b1;

    // Both lanes lock in cycle 2: the flag is up in cycles 4..6 and drops in 7 (hs falls in 6).
    foreach (vecs[i]) begin
      play(mk(8 + int'(vecs[i].k0), vecs[i].p0, 8'h33),
           mk(8 + int'(vecs[i].k1), vecs[i].p1, 8'h44), 6, 8, -1);
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("v%0d c%0d err", i, c), 32'(obs_err[c]), 32'h0);
        chk($sformatf("v%0d c%0d flag", i, c), 32'(obs_flag[c]), 32'(c >= 4 && c <= 6));
        if (c != 6) begin
          chk($sformatf("v%0d c%0d data0", i, c), 32'(obs_d0[c]),
              (c == 4) ? 32'(vecs[i].exp_d0) : (c == 5) ? 32'(vecs[i].exp_d0b) : 32'h0);
          chk($sformatf("v%0d c%0d data1", i, c), 32'(obs_d1[c]),
              (c == 4) ? 32'(vecs[i].exp_d1) : (c == 5) ? 32'(vecs[i].exp_d1b) : 32'h0);
        end
      end
      chk($sformatf("v%0d off0", i), 32'(obs_o0[4]), 32'(vecs[i].exp_off0));
      chk($sformatf("v%0d off1", i), 32'(obs_o1[4]), 32'(vecs[i].exp_off1));
      chk($sformatf("v%0d off0 held", i), 32'(obs_o0[7]), 32'(vecs[i].exp_off0));
      chk($sformatf("v%0d off1 held", i), 32'(obs_o1[7]), 32'(vecs[i].exp_off1));
    end

    // Timeout: no sync through hunt cycles 1..8, so one error in cycle 8. A sync that arrives
    // later (recognised in cycle 11) is ignored while parked.
    play(mk(80, 8'h77, 8'h77), mk(80, 8'h77, 8'h77), 14, 15, -1);
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("tmo c%0d err", c), 32'(obs_err[c]), 32'(c == 8));
      chk($sformatf("tmo c%0d flag", c), 32'(obs_flag[c]), 32'h0);
      chk($sformatf("tmo c%0d data0", c), 32'(obs_d0[c]), 32'h0);
    end

    // Match in the same cycle as the timeout (cycle 8): the match wins, and the flag rises in 10.
    play(mk(56, 8'h6B, 8'h00), mk(60, 8'h9D, 8'h00), 12, 12, -1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("race c%0d err", c), 32'(obs_err[c]), 32'h0);
      chk($sformatf("race c%0d flag", c), 32'(obs_flag[c]), 32'(c >= 10));
    end
    chk("race data0", 32'(obs_d0[10]), 32'h6B);
    chk("race data1", 32'(obs_d1[10]), 32'h9D);
    chk("race off1", 32'(obs_o1[10]), 32'h4);

    // Lane0 locks in cycle 2, and lane1 (offset 2) locks in cycle 3.
    play(mk(8, 8'hC1, 8'hC2), mk(18, 8'hD1, 8'hD2), 8, 8, -1);
`ifdef DPHY_SKEW_COMP_EN
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("skew c%0d err", c), 32'(obs_err[c]), 32'h0);
      chk($sformatf("skew c%0d flag", c), 32'(obs_flag[c]), 32'(c >= 5));
    end
    chk("skew data0", 32'(obs_d0[5]), 32'hC1);
    chk("skew data1", 32'(obs_d1[5]), 32'hD1);
    chk("skew data0 next", 32'(obs_d0[6]), 32'hC2);
    chk("skew data1 next", 32'(obs_d1[6]), 32'hD2);
    chk("skew off0", 32'(obs_o0[5]), 32'h0);
    chk("skew off1", 32'(obs_o1[5]), 32'h2);
`else
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("skew c%0d err", c), 32'(obs_err[c]), 32'(c == 2));
      chk($sformatf("skew c%0d flag", c), 32'(obs_flag[c]), 32'h0);
    end
`endif

    // Asynchronous reset in cycle 4 of a burst, while the flag is high.
    play(mk(11, 8'hA5, 8'h00), mk(13, 8'h5A, 8'h00), 8, 5, 4);
    chk("pre-reset flag", 32'(obs_flag[4]), 32'h1);
    chk("pre-reset data0", 32'(obs_d0[4]), 32'hA5);

    // After reset, the block locks again once hs_active is seen high in the idle state.
    play(mk(9, 8'h5C, 8'h00), mk(12, 8'hE7, 8'h00), 6, 6, -1);
    chk("post-reset flag", 32'(obs_flag[4]), 32'h1);
    chk("post-reset data0", 32'(obs_d0[4]), 32'h5C);
    chk("post-reset data1", 32'(obs_d1[4]), 32'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
